multi_alarm_clk: RTL and testbench
==================================

MULTI_ALARM_CLK -- requirements
Module: multi_alarm_clk

Interface
REQ-001 Parameter TICKS_PER_SEC, default 5000: Clock_5K cycles per second (>=2).
REQ-002 Parameter NUM_ALARMS, default 4: number of independent alarm slots (>=2); AW = $clog2(NUM_ALARMS).
REQ-003 Parameter SNOOZE_SECS, default 300: snooze duration in seconds.
REQ-004 Parameter RING_SECS, default 60: ring duration in seconds before auto-stop.
REQ-005 Clock_5K  in  1  sole clock; all state on rising edge.
REQ-006 Reset  in  1  synchronous, active-low reset, sampled on rising Clock_5K.
REQ-007 LoadTime  in  1  load SetHours/SetMins/SetSecs/Set_AM_PM into time-of-day.
REQ-008 SetHours 4, SetMins 6, SetSecs 6, Set_AM_PM 1  in  time load values (AM_PM: 0=AM, 1=PM).
REQ-009 LoadAlm  in  1  write alarm slot AlmSel.
REQ-010 AlmSel  in  AW  alarm slot index for LoadAlm.
REQ-011 AlarmHoursIn 4, AlarmMinsIn 6, Alarm_AM_PM_In 1  in  alarm load values.
REQ-012 AlarmEnable  in  NUM_ALARMS  per-slot enable.
REQ-013 Snooze  in  1  level, sampled each cycle; Dismiss  in  1  likewise.
REQ-014 Hours 4, Mins 6, Secs 6, AM_PM 1  out  current time, registered.
REQ-015 Alarm  out  1  high while ringing; AlarmId  out  AW  slot that caused the current ring/snooze.
REQ-016 Tick_1Sec  out  1  one-cycle pulse, coincident with each time advance.

Function
REQ-017 Prescaler SHALL count 0..TICKS_PER_SEC-1 and wrap; the edge on which it wraps is the tick edge.
REQ-018 On a tick edge Secs SHALL increment; 59->0 carries to Mins; Mins 59->0 carries to Hours.
REQ-019 Hours SHALL run 12,1,..,11,12; the 11->12 carry SHALL toggle AM_PM; 12->1 SHALL NOT toggle.
REQ-020 Tick_1Sec SHALL be high in exactly the cycle the new time is first visible on the outputs.
REQ-021 LoadTime with valid values (Hours 1..12, Mins/Secs 0..59) SHALL load time and clear the prescaler, overriding a same-cycle tick; Tick_1Sec SHALL be 0 that cycle.
REQ-022 LoadTime with any invalid field SHALL be ignored entirely; counting continues.
REQ-023 LoadAlm with valid values SHALL write slot AlmSel; invalid values or AlmSel >= NUM_ALARMS SHALL be ignored.
REQ-024 Match: in the cycle after Tick_1Sec, if Secs==0 and Hours/Mins/AM_PM equal an enabled slot, that slot matches; lowest index wins on multiple matches.
REQ-025 LoadTime SHALL never produce a match, even when loading an alarm time with Secs=0.
REQ-026 FSM states IDLE, RING, SNOOZE; Alarm=1 only in RING.
REQ-027 IDLE->RING on match: AlarmId=slot, ring counter=0; Alarm rises one cycle after Tick_1Sec.
REQ-028 RING: Dismiss->IDLE; else Snooze->SNOOZE with snooze counter=SNOOZE_SECS; else ring counter increments per tick, reaching RING_SECS->IDLE.
REQ-029 SNOOZE: snooze counter decrements per tick; reaching 0->RING with same AlarmId, ring counter=0; Dismiss->IDLE.
REQ-030 Dismiss SHALL take priority over Snooze in the same cycle; Snooze in SNOOZE SHALL be ignored (no restart).
REQ-031 New matches in RING or SNOOZE SHALL be ignored, including the same slot.
REQ-032 AlarmEnable[AlarmId] low in RING or SNOOZE SHALL force IDLE next edge.
REQ-033 LoadTime and LoadAlm SHALL NOT alter FSM state or counters.
REQ-034 AlarmId SHALL hold its last value in IDLE.

Reset
REQ-035 Reset low on an edge SHALL set Hours=12, Mins=0, Secs=0, AM_PM=0, prescaler=0, all slots 12:00 AM, FSM=IDLE, Alarm=0, AlarmId=0, Tick_1Sec=0, counters=0, overriding all other inputs, including mid-ring or mid-snooze.

Verification (TICKS_PER_SEC=4, SNOOZE_SECS=3, RING_SECS=5, NUM_ALARMS=4)
REQ-036 Load 11:59:59 AM, run 4 cycles -> Tick_1Sec once, time 12:00:00 PM; load 12:59:59 PM -> 1:00:00 PM, AM_PM stays 1.
REQ-037 Slots 1 and 2 both 7:30 AM enabled, time 7:29:59 AM -> Alarm rises cycle after tick, AlarmId=1; no Dismiss -> Alarm falls after 5 ticks, FSM IDLE.
REQ-038 Ringing, Snooze pulse -> Alarm=0; after 3 ticks Alarm=1, AlarmId unchanged; Snooze+Dismiss same cycle -> IDLE.
REQ-039 LoadTime 13:00:00, and 5:60:00 -> ignored, time keeps counting; LoadTime 7:30:00 AM matching enabled slot -> no Alarm.
REQ-040 Ringing on slot 0, clear AlarmEnable[0] -> Alarm=0 next edge; Reset low during SNOOZE -> all REQ-035 values next edge.

Source files
------------

// File: rtl/multi_alarm_clk.sv
// Time-of-day clock (12h, AM/PM) with NUM_ALARMS alarm slots, a shared ring/snooze FSM and a 1 s tick.
// The prescaler wrap edge advances the time. Matches are taken from the registered time while Tick_1Sec is high.
module multi_alarm_clk #(
  parameter  int TICKS_PER_SEC = 5000,
  parameter  int NUM_ALARMS    = 4,
  parameter  int SNOOZE_SECS   = 300,
  parameter  int RING_SECS     = 60,
  localparam int AW            = $clog2(NUM_ALARMS)
) (
  input  logic                  Clock_5K,
  input  logic                  Reset,
  input  logic                  LoadTime,
  input  logic [3:0]            SetHours,
  input  logic [5:0]            SetMins,
  input  logic [5:0]            SetSecs,
  input  logic                  Set_AM_PM,
  input  logic                  LoadAlm,
  input  logic [AW-1:0]         AlmSel,
  input  logic [3:0]            AlarmHoursIn,
  input  logic [5:0]            AlarmMinsIn,
  input  logic                  Alarm_AM_PM_In,
  input  logic [NUM_ALARMS-1:0] AlarmEnable,
  input  logic                  Snooze,
  input  logic                  Dismiss,
  output logic [3:0]            Hours,
  output logic [5:0]            Mins,
  output logic [5:0]            Secs,
  output logic                  AM_PM,
  output logic                  Alarm,
  output logic [AW-1:0]         AlarmId,
  output logic                  Tick_1Sec
);

  localparam int PW   = $clog2(TICKS_PER_SEC);
  localparam int MAXC = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   presc;
  logic [CW-1:0]   ring_cnt, ring_cnt_nx, snz_cnt, snz_cnt_nx;
  logic [AW-1:0]   alarm_id_nx, hit_id;
  logic            hit, match;
  logic [3:0]      alm_hours [NUM_ALARMS];
  logic [5:0]      alm_mins  [NUM_ALARMS];
  logic            alm_pm    [NUM_ALARMS];

  logic tick, time_ok, alm_ok, adv;
  assign tick    = (presc == PW'(TICKS_PER_SEC - 1));
  assign time_ok = LoadTime && (SetHours != 4'd0) && (SetHours <= 4'd12) &&
                   (SetMins <= 6'd59) && (SetSecs <= 6'd59);
  assign alm_ok  = LoadAlm && (AlarmHoursIn != 4'd0) && (AlarmHoursIn <= 4'd12) &&
                   (AlarmMinsIn <= 6'd59) && (32'(AlmSel) < NUM_ALARMS);
  // A valid load swallows a coincident tick, so nothing downstream sees it.
  assign adv     = tick && !time_ok;

  always_ff @(posedge Clock_5K) begin
    if (!Reset) begin
      presc     <= '0;
      Hours     <= 4'd12;
      Mins      <= '0;
      Secs      <= '0;
      AM_PM     <= 1'b0;
      Tick_1Sec <= 1'b0;
    end else begin
      Tick_1Sec <= 1'b0;
      if (time_ok) begin
        presc <= '0;
        Hours <= SetHours;
        Mins  <= SetMins;
        Secs  <= SetSecs;
        AM_PM <= Set_AM_PM;
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) begin
          Tick_1Sec <= 1'b1;
          if (Secs == 6'd59) begin
            Secs <= '0;
            if (Mins == 6'd59) begin
              Mins  <= '0;
              Hours <= (Hours == 4'd12) ? 4'd1 : Hours + 4'd1;
              if (Hours == 4'd11) AM_PM <= ~AM_PM;
            end else begin
              Mins <= Mins + 6'd1;
            end
          end else begin
            Secs <= Secs + 6'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge Clock_5K) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        alm_hours[i] <= 4'd12;
        alm_mins[i]  <= '0;
        alm_pm[i]    <= 1'b0;
      end
    end else if (alm_ok) begin
      alm_hours[AlmSel] <= AlarmHoursIn;
      alm_mins[AlmSel]  <= AlarmMinsIn;
      alm_pm[AlmSel]    <= Alarm_AM_PM_In;
    end
  end

  // Scan downward so the lowest matching slot is the one left standing.
  always_comb begin
    hit    = 1'b0;
    hit_id = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (AlarmEnable[i] && alm_hours[i] == Hours && alm_mins[i] == Mins && alm_pm[i] == AM_PM) begin
        hit    = 1'b1;
        hit_id = AW'(i);
      end
    end
  end
  assign match = hit && Tick_1Sec && (Secs == 6'd0);

  always_ff @(posedge Clock_5K) begin
    if (!Reset) begin
      state    <= IDLE;
      ring_cnt <= '0;
      snz_cnt  <= '0;
      AlarmId  <= '0;
    end else begin
      state    <= state_nx;
      ring_cnt <= ring_cnt_nx;
      snz_cnt  <= snz_cnt_nx;
      AlarmId  <= alarm_id_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    ring_cnt_nx = ring_cnt;
    snz_cnt_nx  = snz_cnt;
    alarm_id_nx = AlarmId;
    case (state)
      IDLE: if (match) begin
        state_nx    = RING;
        ring_cnt_nx = '0;
        alarm_id_nx = hit_id;
      end
      RING: begin
        if (!AlarmEnable[AlarmId] || Dismiss) begin
          state_nx = IDLE;
        end else if (Snooze) begin
          state_nx   = SNOOZE;
          snz_cnt_nx = CW'(SNOOZE_SECS);
        end else if (adv) begin
          if (ring_cnt >= CW'(RING_SECS - 1)) state_nx = IDLE;
          else ring_cnt_nx = ring_cnt + 1'b1;
        end
      end
      SNOOZE: begin
        if (!AlarmEnable[AlarmId] || Dismiss) begin
          state_nx = IDLE;
        end else if (adv) begin
          if (snz_cnt <= CW'(1)) begin
            state_nx    = RING;
            ring_cnt_nx = '0;
          end else begin
            snz_cnt_nx = snz_cnt - 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign Alarm = (state == RING);

endmodule

// File: tb/tb_multi_alarm_clk.sv
// Directed bench for multi_alarm_clk at 4 ticks/s, 3 s snooze, 5 s ring, 4 slots.
// Inputs change 1 ns after a rising edge; outputs are checked at that same point.
module tb_multi_alarm_clk;

  logic       Clock_5K = 1'b0;
  logic       Reset = 1'b0, LoadTime = 1'b0, Set_AM_PM = 1'b0;
  logic [3:0] SetHours = '0;
  logic [5:0] SetMins = '0, SetSecs = '0;
  logic       LoadAlm = 1'b0, Alarm_AM_PM_In = 1'b0;
  logic [1:0] AlmSel = '0;
  logic [3:0] AlarmHoursIn = '0;
  logic [5:0] AlarmMinsIn = '0;
  logic [3:0] AlarmEnable = '0;
  logic       Snooze = 1'b0, Dismiss = 1'b0;
  logic [3:0] Hours;
  logic [5:0] Mins, Secs;
  logic       AM_PM, Alarm, Tick_1Sec;
  logic [1:0] AlarmId;

  int n_tests = 0;
  int n_fail  = 0;

  multi_alarm_clk #(.TICKS_PER_SEC(4), .NUM_ALARMS(4), .SNOOZE_SECS(3), .RING_SECS(5)) dut (
    .Clock_5K(Clock_5K), .Reset(Reset), .LoadTime(LoadTime), .SetHours(SetHours),
    .SetMins(SetMins), .SetSecs(SetSecs), .Set_AM_PM(Set_AM_PM), .LoadAlm(LoadAlm),
    .AlmSel(AlmSel), .AlarmHoursIn(AlarmHoursIn), .AlarmMinsIn(AlarmMinsIn),
    .Alarm_AM_PM_In(Alarm_AM_PM_In), .AlarmEnable(AlarmEnable), .Snooze(Snooze),
    .Dismiss(Dismiss), .Hours(Hours), .Mins(Mins), .Secs(Secs), .AM_PM(AM_PM),
    .Alarm(Alarm), .AlarmId(AlarmId), .Tick_1Sec(Tick_1Sec)
  );

  always #5 Clock_5K = ~Clock_5K;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] tp(input int h, input int m, input int s, input int pm);
    return {15'd0, pm[0], h[3:0], m[5:0], s[5:0]};
  endfunction

  function automatic logic [31:0] now();
    return {15'd0, AM_PM, Hours, Mins, Secs};
  endfunction

  task automatic step();
    @(posedge Clock_5K);
    #1;
  endtask

  task automatic load_time(input int h, input int m, input int s, input int pm);
    SetHours = h[3:0]; SetMins = m[5:0]; SetSecs = s[5:0]; Set_AM_PM = pm[0];
    LoadTime = 1'b1;
    step();
    LoadTime = 1'b0;
  endtask

  task automatic load_alm(input int sel, input int h, input int m, input int pm);
    AlmSel = sel[1:0]; AlarmHoursIn = h[3:0]; AlarmMinsIn = m[5:0]; Alarm_AM_PM_In = pm[0];
    LoadAlm = 1'b1;
    step();
    LoadAlm = 1'b0;
  endtask

  // 7:29:59 AM -> tick on the 4th edge shows 7:30:00, Alarm one edge later.
  task automatic ring_up(input int id);
    load_time(7, 29, 59, 0);
    repeat (3) step();
    step();
    chk("ring_tick", Tick_1Sec, 1);
    chk("ring_time", now(), tp(7, 30, 0, 0));
    chk("ring_pre", Alarm, 0);
    step();
    chk("ring_rise", Alarm, 1);
    chk("ring_id", AlarmId, id);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n, cyc, hi;
    #1;
    step();
    chk("rst_time", now(), tp(12, 0, 0, 0));
    chk("rst_alarm", Alarm, 0);
    chk("rst_id", AlarmId, 0);
    chk("rst_tick", Tick_1Sec, 0);
    step();
    Reset = 1'b1;

    // 11:59:59 AM rolls to 12:00:00 PM after exactly four edges
    load_time(11, 59, 59, 0);
    chk("ld_tick0", Tick_1Sec, 0);
    chk("ld_time", now(), tp(11, 59, 59, 0));
    n = 0;
    repeat (4) begin step(); if (Tick_1Sec) n++; end
    chk("noon_ticks", n, 1);
    chk("noon_time", now(), tp(12, 0, 0, 1));
    step();
    chk("tick_pulse", Tick_1Sec, 0);

    // load lands on a tick edge: tick suppressed, prescaler restarts
    repeat (2) step();
    load_time(3, 15, 20, 1);
    chk("ldtick_tick", Tick_1Sec, 0);
    chk("ldtick_time", now(), tp(3, 15, 20, 1));
    n = 0;
    repeat (3) begin step(); if (Tick_1Sec) n++; end
    chk("presc_clr", n, 0);
    step();
    chk("presc_tick", Tick_1Sec, 1);
    chk("presc_time", now(), tp(3, 15, 21, 1));

    load_time(12, 59, 59, 1);
    repeat (4) step();
    chk("one_pm", now(), tp(1, 0, 0, 1));

    // invalid loads are dropped and counting carries on
    load_time(5, 10, 0, 0);
    load_time(13, 0, 0, 0);
    chk("bad_hour", now(), tp(5, 10, 0, 0));
    load_time(5, 60, 0, 0);
    chk("bad_min", now(), tp(5, 10, 0, 0));
    load_time(0, 10, 0, 0);
    chk("zero_hour", now(), tp(5, 10, 0, 0));
    step();
    chk("bad_keep_tick", Tick_1Sec, 1);
    chk("bad_keep_time", now(), tp(5, 10, 1, 0));

    // two slots at the same time: lowest index wins, auto-stop after 5 ticks
    load_alm(1, 7, 30, 0);
    load_alm(2, 7, 30, 0);
    AlarmEnable = 4'b0110;
    ring_up(1);
    n = 0; cyc = 0;
    while (Alarm && cyc < 40) begin step(); cyc++; if (Tick_1Sec) n++; end
    chk("ring_ticks", n, 5);
    chk("ring_fall", Alarm, 0);
    chk("ring_fall_tick", Tick_1Sec, 1);

    // snooze for 3 ticks; a second Snooze while snoozing must not restart it
    ring_up(1);
    Snooze = 1'b1;
    step();
    Snooze = 1'b0;
    chk("snz_off", Alarm, 0);
    n = 0; cyc = 0;
    while (!Alarm && cyc < 40) begin
      Snooze = (cyc == 2);
      step(); cyc++;
      if (Tick_1Sec) n++;
    end
    Snooze = 1'b0;
    chk("snz_ticks", n, 3);
    chk("snz_rering", Alarm, 1);
    chk("snz_id", AlarmId, 1);
    Snooze = 1'b1; Dismiss = 1'b1;
    step();
    Snooze = 1'b0; Dismiss = 1'b0;
    chk("dismiss_prio", Alarm, 0);
    hi = 0;
    repeat (20) begin step(); if (Alarm) hi++; end
    chk("dismiss_idle", hi, 0);

    // loading the alarm time itself never rings
    load_time(7, 30, 0, 0);
    hi = Alarm ? 1 : 0;
    repeat (8) begin step(); if (Alarm) hi++; end
    chk("load_nomatch", hi, 0);

    // invalid alarm writes leave slot 2 at 7:30 AM
    load_alm(2, 0, 30, 0);
    load_alm(2, 7, 60, 0);
    load_alm(2, 13, 30, 0);
    AlarmEnable = 4'b0100;
    ring_up(2);
    Dismiss = 1'b1;
    step();
    Dismiss = 1'b0;
    chk("dismiss", Alarm, 0);

    // dropping the enable of the ringing slot stops it
    load_alm(0, 7, 30, 0);
    AlarmEnable = 4'b0001;
    ring_up(0);
    AlarmEnable = 4'b0000;
    step();
    chk("en_clear", Alarm, 0);
    AlarmEnable = 4'b0001;
    hi = 0;
    repeat (20) begin step(); if (Alarm) hi++; end
    chk("en_clear_idle", hi, 0);

    // reset while snoozing
    AlarmEnable = 4'b0110;
    ring_up(1);
    Snooze = 1'b1;
    step();
    Snooze = 1'b0;
    repeat (2) step();
    Reset = 1'b0;
    step();
    chk("mid_rst_time", now(), tp(12, 0, 0, 0));
    chk("mid_rst_alarm", Alarm, 0);
    chk("mid_rst_id", AlarmId, 0);
    chk("mid_rst_tick", Tick_1Sec, 0);
    Reset = 1'b1;
    n = 0;
    repeat (3) begin step(); if (Tick_1Sec) n++; end
    chk("mid_rst_presc", n, 0);
    step();
    chk("mid_rst_first", now(), tp(12, 0, 1, 0));
    hi = 0;
    repeat (20) begin step(); if (Alarm) hi++; end
    chk("mid_rst_idle", hi, 0);

    // slots were reset to 12:00 AM; 11 PM -> 12 AM flips AM_PM back
    AlarmEnable = 4'b0001;
    load_time(11, 59, 59, 1);
    repeat (4) step();
    chk("midnight", now(), tp(12, 0, 0, 0));
    step();
    chk("rst_slot_ring", Alarm, 1);
    chk("rst_slot_id", AlarmId, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
